uart_rx_ex: RTL and testbench

Parametrised UART receiver, the next generation of the single-format RX block. Adds runtime baud divisor, data width 5..9, optional even/odd parity, 1 or 2 stop bits, 3-sample majority voting, and framing/parity/break detection. Also adds a receive FIFO with a valid/ready output handshake and a sticky overrun flag. Sits between the pad-side RX line and any byte consumer (command parser, bridge) in the CLK domain.

---
 rtl/uart_rx_ex.sv | 134 +++++++++++++
 tb/tb_uart_rx_ex.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ex.sv
// uart_rx_ex: UART receiver with runtime divisor, parity, 1/2 stop bits, majority voting, break detect and FWFT receive FIFO
`timescale 1ns/1ps
module uart_rx_ex #(
  parameter int DW = 8,
  parameter int DIV_W = 16,
  parameter int FIFO_DEPTH = 4
)(
  input  logic             CLK,
  input  logic             RST,
  input  logic             RX,
  input  logic [DIV_W-1:0] div,
  input  logic [1:0]       parity_mode,
  input  logic             stop2,
  output logic [DW-1:0]    dot,
  output logic             perr,
  output logic             ferr,
  output logic             brk,
  output logic             valid,
  input  logic             ready,
  output logic             ovr,
  input  logic             clr_ovr,
  output logic             busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = DW + 3;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_WAIT} state_t;
  state_t r_state, w_state_nx;
  logic [1:0] r_sync;
  logic [2:0] r_vote;
  logic [DIV_W-1:0] r_div, r_cnt, w_div_eff;
  logic [3:0] r_bitcnt;
  logic [DW-1:0] r_data;
  logic r_par_en, r_odd, r_stop2, r_perr, r_ferr, r_pbit;
  logic w_rx, w_fall, w_tick, w_bit, w_push, w_brk, w_ferr_now;
  logic [FW-1:0] w_word;
  logic [FW-1:0] r_mem [FIFO_DEPTH];
  logic [FW-1:0] r_last;
  logic [AW:0] r_wp, r_rp, w_count;
  logic w_full, w_pop, w_wr;
  assign w_rx = r_sync[1];
  assign w_fall = r_vote[0] & ~w_rx;
  assign w_bit = (r_vote[0] & r_vote[1]) | (r_vote[1] & r_vote[2]) | (r_vote[0] & r_vote[2]);
  assign w_tick = r_cnt == '0 && r_state != S_IDLE && r_state != S_WAIT;
  assign w_div_eff = div < DIV_W'(4) ? DIV_W'(4) : div;
  assign w_brk = r_state == S_STOP1 && r_data == '0 && !(r_par_en && r_pbit) && !w_bit;
  assign w_ferr_now = r_ferr | ~w_bit;
  assign w_word = {w_brk, w_ferr_now, r_perr, r_data};
  assign busy = r_state != S_IDLE;
  always_comb begin
    w_state_nx = r_state;
    w_push = 1'b0;
    case (r_state)
      S_IDLE:   w_state_nx = w_fall ? S_START : S_IDLE;
      S_START:  w_state_nx = w_tick ? (w_bit ? S_IDLE : S_DATA) : S_START;
      S_DATA:   w_state_nx = w_tick && r_bitcnt == 4'(DW-1) ? (r_par_en ? S_PARITY : S_STOP1) : S_DATA;
      S_PARITY: w_state_nx = w_tick ? S_STOP1 : S_PARITY;
      S_STOP1: begin
        w_push = w_tick && !(r_stop2 && !w_brk);
        w_state_nx = !w_tick ? S_STOP1 : (r_stop2 && !w_brk) ? S_STOP2 : w_ferr_now ? S_WAIT : S_IDLE;
      end
      S_STOP2: begin
        w_push = w_tick;
        w_state_nx = !w_tick ? S_STOP2 : w_ferr_now ? S_WAIT : S_IDLE;
      end
      S_WAIT:   w_state_nx = w_rx ? S_IDLE : S_WAIT;
      default:  w_state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) r_state <= S_IDLE;
    else r_state <= w_state_nx;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_sync <= '1;
      r_vote <= '1;
      r_div <= '0;
      r_cnt <= '0;
      r_bitcnt <= '0;
      r_data <= '0;
      r_par_en <= 1'b0;
      r_odd <= 1'b0;
      r_stop2 <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_pbit <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], RX};
      r_vote <= {r_vote[1:0], r_sync[1]};
      if (r_state == S_IDLE && w_fall) begin
        r_div <= w_div_eff;
        r_cnt <= w_div_eff >> 1;
        r_bitcnt <= '0;
        r_perr <= 1'b0;
        r_ferr <= 1'b0;
        r_pbit <= 1'b0;
        r_par_en <= parity_mode == 2'd1 || parity_mode == 2'd2;
        r_odd <= parity_mode == 2'd2;
        r_stop2 <= stop2;
      end else if (w_tick) begin
        r_cnt <= r_div - 1'b1;
        if (r_state == S_DATA) begin
          r_data <= {w_bit, r_data[DW-1:1]};
          r_bitcnt <= r_bitcnt + 1'b1;
        end
        if (r_state == S_PARITY) begin
          r_pbit <= w_bit;
          r_perr <= ^r_data ^ w_bit ^ r_odd;
        end
        if (r_state == S_STOP1) r_ferr <= ~w_bit;
      end else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
  assign w_count = r_wp - r_rp;
  assign valid = r_wp != r_rp;
  assign w_full = w_count == (AW+1)'(FIFO_DEPTH);
  assign w_pop = valid & ready;
  assign w_wr = w_push & (~w_full | w_pop);
  assign {brk, ferr, perr, dot} = valid ? r_mem[r_rp[AW-1:0]] : r_last;
  always_ff @(posedge CLK)
    if (w_wr) r_mem[r_wp[AW-1:0]] <= w_word;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_wp <= '0;
      r_rp <= '0;
      r_last <= '0;
      ovr <= 1'b0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
        r_last <= r_mem[r_rp[AW-1:0]];
      end
      ovr <= (w_push & w_full & ~w_pop) ? 1'b1 : clr_ovr ? 1'b0 : ovr;
    end
endmodule

// File: tb/tb_uart_rx_ex.sv
// tb_uart_rx_ex: randomized scoreboard bench for uart_rx_ex
`timescale 1ns/1ps
module tb_uart_rx_ex;
  localparam int DW = 8;
  localparam int DIV_W = 16;
  localparam int DEPTH = 4;
  logic CLK = 1'b0, RST = 1'b1, RX = 1'b1;
  logic [DIV_W-1:0] div = 16;
  logic [1:0] parity_mode = 2'd0;
  logic stop2 = 1'b0, ready = 1'b1, clr_ovr = 1'b0;
  logic [DW-1:0] dot;
  logic perr, ferr, brk, valid, ovr, busy;
  int n_chk = 0, n_pass = 0;
  logic [DW+2:0] q[$];
  logic exp_ovr = 1'b0;
  uart_rx_ex #(.DW(DW), .DIV_W(DIV_W), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .RX(RX), .div(div), .parity_mode(parity_mode), .stop2(stop2),
    .dot(dot), .perr(perr), .ferr(ferr), .brk(brk), .valid(valid), .ready(ready),
    .ovr(ovr), .clr_ovr(clr_ovr), .busy(busy)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  always @(negedge CLK)
    if (!RST && valid && ready) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_word: got 0x%0h expected none", {brk, ferr, perr, dot});
      end else chk("word", 32'({brk, ferr, perr, dot}), 32'(q.pop_front()));
    end
  function automatic logic [DW+2:0] model(input logic [DW-1:0] d, input logic [1:0] pm,
                                          input logic pb, input logic s1, input logic st2, input logic s2);
    bit has_par = pm == 2'd1 || pm == 2'd2;
    int ones = $countones(d) + ((has_par && pb) ? 1 : 0);
    logic b = d == 0 && !(has_par && pb) && !s1;
    logic pe = has_par && ((ones % 2) != (pm == 2'd2 ? 1 : 0));
    logic fe = !s1 || (st2 && !b && !s2);
    return {b, fe, pe, d};
  endfunction
  task automatic expect_word(input logic [DW+2:0] w);
    if (!ready && q.size() >= DEPTH) exp_ovr = 1'b1;
    else q.push_back(w);
  endtask
  task automatic drive(input logic v, input int n);
    RX = v;
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic send(input logic [DW-1:0] d, input int dv, input logic [1:0] pm, input logic pb,
                      input logic s1, input logic st2, input logic s2, input int glitch = -1, input int abort = -1);
    int bl = dv < 4 ? 4 : dv;
    div = DIV_W'(dv);
    parity_mode = pm;
    stop2 = st2;
    if (abort < 0) expect_word(model(d, pm, pb, s1, st2, s2));
    drive(1'b0, bl);
    div = DIV_W'($urandom_range(1, 40));
    for (int i = 0; i < DW; i++) begin
      if (i == abort) begin
        drive(d[i], bl / 2);
        return;
      end
      if (i == glitch) begin
        drive(d[i], bl / 2);
        drive(1'b0, 1);
        drive(d[i], bl - bl / 2 - 1);
      end else drive(d[i], bl);
    end
    if (pm == 2'd1 || pm == 2'd2) drive(pb, bl);
    drive(s1, bl);
    if (st2) drive(s2, bl);
    drive(1'b1, 2 * bl);
  endtask
  task automatic drain();
    for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge CLK);
    chk("drain_left", 32'(q.size()), 0);
    q.delete();
    @(posedge CLK);
    #1;
    chk("valid_after_drain", 32'(valid), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("rst_valid", 32'(valid), 0);
    chk("rst_dot", 32'(dot), 0);
    chk("rst_flags", 32'({brk, ferr, perr}), 0);
    chk("rst_ovr", 32'(ovr), 0);
    chk("rst_busy", 32'(busy), 0);
    repeat (4) @(posedge CLK);
    #1;
    send(8'hA5, 16, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    drain();
    chk("idle_busy", 32'(busy), 0);
    send(8'h03, 16, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    send(8'h03, 16, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    drain();
    div = 16;
    parity_mode = 2'd0;
    stop2 = 1'b0;
    drive(1'b0, 3);
    RX = 1'b1;
    for (int i = 0; i < 10 && busy; i++) begin
      @(posedge CLK);
      #1;
    end
    chk("false_start_busy", 32'(busy), 0);
    drive(1'b1, 32);
    chk("false_start_valid", 32'(valid), 0);
    send(8'hFF, 16, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 3);
    drain();
    div = 16;
    expect_word(model(8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    drive(1'b0, 20 * 16);
    drive(1'b1, 32);
    send(8'h41, 16, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    drain();
    send(8'h3C, 16, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    drain();
    send(8'h96, 2, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1);
    drain();
    for (int n = 0; n < 24; n++) begin
      logic [DW-1:0] d = ($urandom_range(0, 7) == 0) ? 8'h00 : DW'($urandom);
      int dv = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 20);
      send(d, dv, 2'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 5) != 0,
           1'($urandom), $urandom_range(0, 5) != 0);
      drain();
    end
    ready = 1'b0;
    for (int b = 'h10; b <= 'h14; b++) send(8'(b), 8, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("ovr_set", 32'(ovr), 32'(exp_ovr));
    chk("ovr_valid", 32'(valid), 1);
    chk("ovr_head", 32'(dot), 'h10);
    ready = 1'b1;
    drain();
    chk("ovr_sticky", 32'(ovr), 1);
    clr_ovr = 1'b1;
    @(posedge CLK);
    #1;
    clr_ovr = 1'b0;
    chk("ovr_clear", 32'(ovr), 0);
    exp_ovr = 1'b0;
    ready = 1'b0;
    for (int b = 0; b < 5; b++) send(8'($urandom), 4, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("ovr_set2", 32'(ovr), 32'(exp_ovr));
    send(8'h33, 16, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, -1, 4);
    chk("busy_mid_frame", 32'(busy), 1);
    RST = 1'b1;
    RX = 1'b1;
    #1;
    chk("midrst_valid", 32'(valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ovr", 32'(ovr), 0);
    q.delete();
    exp_ovr = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    ready = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    send(8'h5A, 16, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
